// File: rtl/handshake_rr_arbiter.sv
// ---------------------------------------------------------------------------
// handshake_rr_arbiter
//
// Shares one ready/valid operand port of a downstream datapath among three
// upstream requesters. Each cycle in which the output register may be loaded,
// one valid requester is chosen round-robin. Its operand pair is captured into
// a single output register. That register is then offered downstream, tagged
// with the index of the requester it came from, so the response can be routed
// back to that requester.
//
// Ports:
//   CLK            clock, all state changes on the rising edge
//   RESET          synchronous, active-high reset
//   req_i_valid    requester i offers an operand pair        (i = 0..2)
//   req_i_ready    requester i's operands are taken this cycle
//   req_i_in1/in2  requester i operand pair, WIDTH bits each
//   dut_valid      output register holds operands
//   dut_ready      downstream accepts the held operands
//   dut_in1/in2    held operand pair
//   dut_src        index of the requester whose operands are held (0..2)
//   busy           output register is full (HOLD state)
// ---------------------------------------------------------------------------
module handshake_rr_arbiter #(
    parameter int WIDTH = 5,
    parameter int N_REQ = 3
) (
    input  logic             CLK,
    input  logic             RESET,
    input  logic             req_0_valid,
    output logic             req_0_ready,
    input  logic [WIDTH-1:0] req_0_in1,
    input  logic [WIDTH-1:0] req_0_in2,
    input  logic             req_1_valid,
    output logic             req_1_ready,
    input  logic [WIDTH-1:0] req_1_in1,
    input  logic [WIDTH-1:0] req_1_in2,
    input  logic             req_2_valid,
    output logic             req_2_ready,
    input  logic [WIDTH-1:0] req_2_in1,
    input  logic [WIDTH-1:0] req_2_in2,
    output logic             dut_valid,
    input  logic             dut_ready,
    output logic [WIDTH-1:0] dut_in1,
    output logic [WIDTH-1:0] dut_in2,
    output logic [1:0]       dut_src,
    output logic             busy
);

    // The search order and port list are written out for exactly three
    // requesters, so any other count must be rejected at elaboration.
    generate
        if (N_REQ != 3) begin : g_bad_n_req
            $error("handshake_rr_arbiter supports exactly three requesters");
        end
    endgenerate

    localparam logic [0:0] ST_IDLE = 1'b0;
    localparam logic [0:0] ST_HOLD = 1'b1;

    logic [0:0]       state_q, state_d;
    logic [1:0]       ptr_q, ptr_d;
    logic [WIDTH-1:0] in1_q, in1_d;
    logic [WIDTH-1:0] in2_q, in2_d;
    logic [1:0]       src_q, src_d;

    logic [2:0]       valid_vec;
    logic             accept_en;
    logic             grant_any;
    logic [1:0]       win_idx;
    logic [2:0]       ready_vec;
    logic [WIDTH-1:0] sel_in1;
    logic [WIDTH-1:0] sel_in2;

    assign valid_vec = {req_2_valid, req_1_valid, req_0_valid};

    // Round-robin search starting at ptr. ptr never holds 3, but the default
    // branch maps it onto the ptr==0 order so the logic stays fully defined.
    always_comb begin
        win_idx   = 2'd0;
        grant_any = |valid_vec;
        case (ptr_q)
            2'd1: begin
                if      (valid_vec[1]) win_idx = 2'd1;
                else if (valid_vec[2]) win_idx = 2'd2;
                else                   win_idx = 2'd0;
            end
            2'd2: begin
                if      (valid_vec[2]) win_idx = 2'd2;
                else if (valid_vec[0]) win_idx = 2'd0;
                else                   win_idx = 2'd1;
            end
            default: begin
                if      (valid_vec[0]) win_idx = 2'd0;
                else if (valid_vec[1]) win_idx = 2'd1;
                else                   win_idx = 2'd2;
            end
        endcase
    end

    // The register can take new operands when it is empty, or when its
    // current contents leave downstream in this same cycle. Ready is
    // suppressed during reset, because a reset edge discards any capture.
    always_comb begin
        accept_en = (state_q == ST_IDLE) || dut_ready;
        ready_vec = 3'b000;
        if (accept_en && grant_any && !RESET) begin
            ready_vec[win_idx] = 1'b1;
        end
    end

    // Operand mux for the winning requester.
    always_comb begin
        case (win_idx)
            2'd1:    begin sel_in1 = req_1_in1; sel_in2 = req_1_in2; end
            2'd2:    begin sel_in1 = req_2_in1; sel_in2 = req_2_in2; end
            default: begin sel_in1 = req_0_in1; sel_in2 = req_0_in2; end
        endcase
    end

    // Next-state logic. An upstream capture has priority over emptying the
    // register: when both happen in one cycle, the state stays in HOLD with
    // new data. This is what allows one transfer per cycle.
    always_comb begin
        state_d = state_q;
        ptr_d   = ptr_q;
        in1_d   = in1_q;
        in2_d   = in2_q;
        src_d   = src_q;
        if (accept_en && grant_any) begin
            state_d = ST_HOLD;
            in1_d   = sel_in1;
            in2_d   = sel_in2;
            src_d   = win_idx;
            ptr_d   = (win_idx == 2'd2) ? 2'd0 : win_idx + 2'd1;
        end else if (state_q == ST_HOLD && dut_ready) begin
            state_d = ST_IDLE;
        end
    end

    // State registers. Reset empties the register and clears the held data.
    always_ff @(posedge CLK) begin
        if (RESET) begin
            state_q <= ST_IDLE;
            ptr_q   <= 2'd0;
            in1_q   <= '0;
            in2_q   <= '0;
            src_q   <= 2'd0;
        end else begin
            state_q <= state_d;
            ptr_q   <= ptr_d;
            in1_q   <= in1_d;
            in2_q   <= in2_d;
            src_q   <= src_d;
        end
    end

    assign req_0_ready = ready_vec[0];
    assign req_1_ready = ready_vec[1];
    assign req_2_ready = ready_vec[2];
    assign dut_valid   = (state_q == ST_HOLD);
    assign busy        = (state_q == ST_HOLD);
    assign dut_in1     = in1_q;
    assign dut_in2     = in2_q;
    assign dut_src     = src_q;

endmodule

// File: tb/tb_handshake_rr_arbiter.sv
// ---------------------------------------------------------------------------
// tb_handshake_rr_arbiter
//
// Drives the arbiter with directed scenarios and then with random traffic.
// Every cycle, each output is compared against a small reference model of
// the arbitration rules. That model tracks the pointer as an integer, the
// register as a full flag, and the held data.
// ---------------------------------------------------------------------------
module tb_handshake_rr_arbiter;

    localparam int WIDTH = 5;

    logic             CLK = 1'b0;
    logic             RESET;
    logic             req_0_valid, req_1_valid, req_2_valid;
    logic             req_0_ready, req_1_ready, req_2_ready;
    logic [WIDTH-1:0] req_0_in1, req_0_in2;
    logic [WIDTH-1:0] req_1_in1, req_1_in2;
    logic [WIDTH-1:0] req_2_in1, req_2_in2;
    logic             dut_valid, dut_ready, busy;
    logic [WIDTH-1:0] dut_in1, dut_in2;
    logic [1:0]       dut_src;

    handshake_rr_arbiter #(.WIDTH(WIDTH), .N_REQ(3)) dut (
        .CLK(CLK), .RESET(RESET),
        .req_0_valid(req_0_valid), .req_0_ready(req_0_ready),
        .req_0_in1(req_0_in1), .req_0_in2(req_0_in2),
        .req_1_valid(req_1_valid), .req_1_ready(req_1_ready),
        .req_1_in1(req_1_in1), .req_1_in2(req_1_in2),
        .req_2_valid(req_2_valid), .req_2_ready(req_2_ready),
        .req_2_in1(req_2_in1), .req_2_in2(req_2_in2),
        .dut_valid(dut_valid), .dut_ready(dut_ready),
        .dut_in1(dut_in1), .dut_in2(dut_in2), .dut_src(dut_src),
        .busy(busy)
    );

    always #5 CLK = ~CLK;

    int checks = 0;
    int passes = 0;

    // Reference model state
    int         m_ptr;
    bit         m_hold;
    logic [4:0] m_in1, m_in2;
    logic [1:0] m_src;

    // Index of the requester the DUT readied in the last stimulus cycle.
    // The value 3 means none was readied.
    int obs_grant;

    // Compare one observed value with its expected value and record the result.
    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs === exp) passes++;
        else $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h at %0t", tag, obs, exp, $time);
    endtask

    task automatic model_reset();
        m_ptr  = 0;
        m_hold = 0;
        m_in1  = '0;
        m_in2  = '0;
        m_src  = '0;
    endtask

    // Drive one cycle of inputs, check all outputs against the model, then
    // step the model across the rising edge.
    task automatic applyStimulus(input logic rst, input logic [2:0] v, input logic dr,
                                 input logic [4:0] a0, input logic [4:0] b0,
                                 input logic [4:0] a1, input logic [4:0] b1,
                                 input logic [4:0] a2, input logic [4:0] b2);
        logic [4:0] a [3];
        logic [4:0] b [3];
        int         w;
        bit         acc;
        logic [2:0] exp_ready;
        logic [2:0] got_ready;
        @(negedge CLK);
        RESET = rst;
        {req_2_valid, req_1_valid, req_0_valid} = v;
        dut_ready = dr;
        req_0_in1 = a0; req_0_in2 = b0;
        req_1_in1 = a1; req_1_in2 = b1;
        req_2_in1 = a2; req_2_in2 = b2;
        a[0] = a0; a[1] = a1; a[2] = a2;
        b[0] = b0; b[1] = b1; b[2] = b2;
        #1;
        w = -1;
        for (int k = 0; k < 3; k++) begin
            int i;
            i = (m_ptr + k) % 3;
            if (w < 0 && v[i]) w = i;
        end
        acc = !rst && (!m_hold || dr) && (w >= 0);
        exp_ready = acc ? (3'b001 << w) : 3'b000;
        got_ready = {req_2_ready, req_1_ready, req_0_ready};
        obs_grant = 3;
        for (int i = 0; i < 3; i++) if (got_ready[i]) obs_grant = i;
        checkOutput("req_ready", 32'(got_ready), 32'(exp_ready));
        checkOutput("dut_valid", 32'(dut_valid), 32'(m_hold));
        checkOutput("busy", 32'(busy), 32'(m_hold));
        checkOutput("dut_in1", 32'(dut_in1), 32'(m_in1));
        checkOutput("dut_in2", 32'(dut_in2), 32'(m_in2));
        checkOutput("dut_src", 32'(dut_src), 32'(m_src));
        @(posedge CLK);
        if (rst) begin
            model_reset();
        end else if (acc) begin
            m_in1  = a[w];
            m_in2  = b[w];
            m_src  = 2'(w);
            m_ptr  = (w + 1) % 3;
            m_hold = 1;
        end else if (m_hold && dr) begin
            m_hold = 0;
        end
    endtask

    task automatic do_reset();
        applyStimulus(1'b1, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0);
    endtask

    initial begin
        RESET = 1'b1;
        {req_2_valid, req_1_valid, req_0_valid} = 3'b000;
        dut_ready = 1'b0;
        req_0_in1 = '0; req_0_in2 = '0;
        req_1_in1 = '0; req_1_in2 = '0;
        req_2_in1 = '0; req_2_in2 = '0;
        obs_grant = 3;
        repeat (2) @(posedge CLK);
        model_reset();
        do_reset();

        // Requester 1 alone
        applyStimulus(1'b0, 3'b010, 1'b1, 0, 0, 5'h0A, 5'h03, 0, 0);
        checkOutput("t1_grant", 32'(obs_grant), 32'd1);
        #2;
        checkOutput("t1_valid", 32'(dut_valid), 32'd1);
        checkOutput("t1_in1", 32'(dut_in1), 32'h0A);
        checkOutput("t1_in2", 32'(dut_in2), 32'h03);
        checkOutput("t1_src", 32'(dut_src), 32'd1);
        applyStimulus(1'b0, 3'b111, 1'b1, 1, 1, 2, 2, 3, 3);
        checkOutput("t1_ptr2", 32'(obs_grant), 32'd2);

        // All valid: grants rotate 0,1,2 with no bubbles
        do_reset();
        for (int k = 0; k < 6; k++) begin
            applyStimulus(1'b0, 3'b111, 1'b1, 5'(k), 5'(k + 8), 5'(k + 1), 5'(k + 9), 5'(k + 2), 5'(k + 10));
            checkOutput("rr_seq", 32'(obs_grant), 32'(k % 3));
        end

        // Backpressure: requester 2 is held while downstream stalls
        do_reset();
        applyStimulus(1'b0, 3'b100, 1'b1, 0, 0, 0, 0, 5'h1F, 5'h05);
        checkOutput("bp_grant2", 32'(obs_grant), 32'd2);
        for (int k = 0; k < 4; k++) begin
            applyStimulus(1'b0, 3'b011, 1'b0, 5'h01, 5'h02, 5'h03, 5'h04, 0, 0);
            checkOutput("bp_noready", 32'(obs_grant), 32'd3);
            checkOutput("bp_in1", 32'(dut_in1), 32'h1F);
            checkOutput("bp_src", 32'(dut_src), 32'd2);
        end
        applyStimulus(1'b0, 3'b011, 1'b1, 5'h01, 5'h02, 5'h03, 5'h04, 0, 0);
        checkOutput("bp_resume0", 32'(obs_grant), 32'd0);

        // Drain
        do_reset();
        applyStimulus(1'b0, 3'b001, 1'b1, 5'h07, 5'h08, 0, 0, 0, 0);
        applyStimulus(1'b0, 3'b000, 1'b1, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("drain_valid", 32'(dut_valid), 32'd0);
        checkOutput("drain_busy", 32'(busy), 32'd0);
        applyStimulus(1'b0, 3'b111, 1'b1, 1, 1, 2, 2, 3, 3);
        checkOutput("drain_ptr1", 32'(obs_grant), 32'd1);

        // Reset while holding
        do_reset();
        applyStimulus(1'b0, 3'b001, 1'b0, 5'h11, 5'h12, 0, 0, 0, 0);
        applyStimulus(1'b0, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0);
        applyStimulus(1'b1, 3'b000, 1'b0, 0, 0, 0, 0, 0, 0);
        #2;
        checkOutput("rst_valid", 32'(dut_valid), 32'd0);
        checkOutput("rst_in1", 32'(dut_in1), 32'd0);
        applyStimulus(1'b0, 3'b100, 1'b0, 0, 0, 0, 0, 5'h15, 5'h16);
        checkOutput("rst_grant2", 32'(obs_grant), 32'd2);
        applyStimulus(1'b0, 3'b111, 1'b1, 1, 1, 2, 2, 3, 3);
        checkOutput("rst_ptr_after", 32'(obs_grant), 32'd0);

        // Requester 1 drops valid before being granted
        do_reset();
        applyStimulus(1'b0, 3'b011, 1'b1, 5'h02, 5'h03, 5'h04, 5'h05, 0, 0);
        checkOutput("drop_win0", 32'(obs_grant), 32'd0);
        applyStimulus(1'b0, 3'b100, 1'b1, 0, 0, 0, 0, 5'h06, 5'h07);
        checkOutput("drop_skip1", 32'(obs_grant), 32'd2);

        // Random traffic with occasional resets
        for (int k = 0; k < 400; k++) begin
            applyStimulus($urandom_range(0, 49) == 0, 3'($urandom), 1'($urandom),
                          5'($urandom), 5'($urandom), 5'($urandom),
                          5'($urandom), 5'($urandom), 5'($urandom));
        end

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule

// File: doc/handshake_rr_arbiter.md
Name: handshake_rr_arbiter

Overview:
- Shares one ready/valid operand port of the downstream RTL datapath among three upstream requesters.
- Each requester offers an operand pair (in1, in2) on its own handshake. The block picks one requester round-robin and registers its operands.
- It then presents the registered operands on a single downstream handshake, tagged with the source index, so the response can be routed back.

Parameters:
- WIDTH, 5, bit width of each operand (in1, in2).
- N_REQ, 3, number of requesters. Fixed at 3; any other value is a compile-time error.

Ports:
- CLK  input  1  clock; all state updates on rising edge.
- RESET  input  1  synchronous, active-high reset.
- req_0_valid  input  1  requester 0 offers operands.
- req_0_ready  output  1  requester 0 operands accepted this cycle.
- req_0_in1  input  WIDTH  requester 0 operand 1.
- req_0_in2  input  WIDTH  requester 0 operand 2.
- req_1_valid, req_1_ready, req_1_in1, req_1_in2: same as requester 0, for requester 1.
- req_2_valid, req_2_ready, req_2_in1, req_2_in2: same as requester 0, for requester 2.
- dut_valid  output  1  registered operands available downstream.
- dut_ready  input  1  downstream accepts operands.
- dut_in1  output  WIDTH  registered operand 1.
- dut_in2  output  WIDTH  registered operand 2.
- dut_src  output  2  index of the requester whose operands are held (0..2).
- busy  output  1  high while the state is HOLD.

Behaviour:
- Reset:
  - Clock and reset are fixed: one clock, CLK; reset RESET is synchronous and active-high.
  - Reset is sampled on a CLK rising edge and dominates all other inputs.
  - Reset values: state=IDLE, ptr=0, dut_valid=0, dut_in1=0, dut_in2=0, dut_src=0, busy=0.
  - All req_i_ready are 0 while RESET=1.
- States:
  - IDLE: output register empty.
  - HOLD: output register full, dut_valid=1.
- Accept window: accept_en = (state==IDLE) or (state==HOLD and dut_ready).
- Grant selection (combinational):
  - Search requesters starting at ptr, in order ptr, ptr+1, ptr+2 (mod 3).
  - The first with req_i_valid=1 is the winner.
  - grant_any = OR of the three valid inputs.
- Ready generation:
  - req_i_ready = accept_en & grant_any & (winner==i). It is combinational from valid, ptr, state and dut_ready.
  - At most one req_i_ready is high in any cycle.
- Transfer: an upstream transfer occurs for requester i when req_i_valid & req_i_ready. On that edge:
  - dut_in1 <= req_i_in1, dut_in2 <= req_i_in2, dut_src <= i.
  - ptr <= (i+1) mod 3.
  - state <= HOLD.
- Transitions:
  - IDLE, no valid: stay IDLE. ptr and data registers unchanged.
  - IDLE, any valid: accept the winner, go to HOLD. Latency from req valid to dut_valid is 1 cycle.
  - HOLD, dut_ready=0: stay HOLD. dut_in1, dut_in2 and dut_src are held stable; all req_i_ready=0.
  - HOLD, dut_ready=1, no valid: downstream transfer; go IDLE, dut_valid <= 0.
  - HOLD, dut_ready=1, a valid present: downstream transfer and upstream accept in the same cycle; stay HOLD with the new data. This gives full throughput, one transfer per cycle.
- Fairness:
  - A requester that holds valid continuously is granted within 3 accepts.
  - ptr only advances on an upstream transfer.
- dut_valid is never deasserted without a downstream transfer, except by RESET.
- Reset mid-operation: held operands are discarded, with no downstream transfer. The requester that was granted earlier is not re-offered by this block.
- The arbiter does not require a requester to keep valid high until ready. A requester that drops valid is simply skipped.
- Operands pass through unmodified, with no arithmetic or width change. dut_src encodes 0, 1, 2; value 3 never appears.
- Assertions the verification engineer binds:
  - onehot0 of {req_2_ready, req_1_ready, req_0_ready}.
  - dut_valid & !dut_ready |=> $stable(dut_in1, dut_in2, dut_src).
  - dut_src != 3.

Test Plan:
- Reset, then requester 1 alone: in1=5'h0A, in2=5'h03 with dut_ready=1.
  - req_1_ready is high in cycle 0.
  - In cycle 1: dut_valid=1, dut_in1=0A, dut_in2=03, dut_src=1.
  - ptr becomes 2.
- All three valid continuously, dut_ready=1 after reset.
  - Grants go 0,1,2,0,1,2 on consecutive cycles.
  - dut_src follows the same sequence one cycle later; dut_valid stays 1 with no bubbles.
- Backpressure: requester 2 is granted with in1=5'h1F, then dut_ready=0 for 4 cycles while requesters 0 and 1 are valid.
  - dut_in1 stays 1F and dut_src stays 2 for the whole stall.
  - All req_i_ready=0 during the stall.
  - On the cycle dut_ready returns to 1, requester 0 is granted.
- Drain: single transfer from requester 0, then no valid with dut_ready=1.
  - dut_valid drops to 0 the cycle after the downstream transfer; busy=0.
  - ptr remains 1.
- Reset mid-HOLD: requester 0 holds 5'h11 with dut_ready=0, and RESET=1 is applied for one cycle.
  - The next cycle shows dut_valid=0, dut_in1=0, ptr=0.
  - A subsequent request from requester 2 is granted normally.
- Valid dropped before grant: requester 1 is valid for one cycle while requester 0 wins; requester 1 then drops valid.
  - Requester 1 is never readied.
  - ptr becomes 1, and the next valid requester in search order is granted.
